// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x W register file with one write port and two combinational read ports.
// Synchronous active-low reset clears every entry and overrides a same-cycle write.
module reg_file #(
    parameter int W      = 3,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      DATA_in,
    input  logic [ADDR_W-1:0] adr_dst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] adr_src1,
    input  logic [ADDR_W-1:0] adr_src2,
    output logic [W-1:0]      DATA_out_1,
    output logic [W-1:0]      DATA_out_2
);
    localparam int N = 1 << ADDR_W;

    logic [W-1:0] regs_q [N];
    logic [W-1:0] regs_d [N];

    always_comb begin
        regs_d = regs_q;
        if (write_enable) regs_d[adr_dst] = DATA_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads come straight from storage, so a same-address write is visible only after the edge.
    assign DATA_out_1 = regs_q[adr_src1];
    assign DATA_out_2 = regs_q[adr_src2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed bench for reg_file with a scoreboard queue of expected read values.
module tb_reg_file;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] DATA_in;
    logic [1:0] adr_dst;
    logic       write_enable;
    logic [1:0] adr_src1;
    logic [1:0] adr_src2;
    logic [2:0] DATA_out_1;
    logic [2:0] DATA_out_2;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb [$];
    logic [2:0] vals [4];

    reg_file #(.W(3), .ADDR_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .DATA_in(DATA_in),
        .adr_dst(adr_dst),
        .write_enable(write_enable),
        .adr_src1(adr_src1),
        .adr_src2(adr_src2),
        .DATA_out_1(DATA_out_1),
        .DATA_out_2(DATA_out_2)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [2:0] e);
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [2:0] obs);
        logic [2:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_pair(input string tag, input logic [1:0] a1, input logic [1:0] a2,
                             input logic [2:0] e1, input logic [2:0] e2);
        adr_src1 = a1;
        adr_src2 = a2;
        push(e1);
        push(e2);
        #1;
        check({tag, "_p1"}, DATA_out_1);
        check({tag, "_p2"}, DATA_out_2);
    endtask

    initial begin
        vals[0] = 3'b101;
        vals[1] = 3'b010;
        vals[2] = 3'b111;
        vals[3] = 3'b001;
        reset = 1'b0;
        DATA_in = 3'b000;
        adr_dst = 2'd0;
        write_enable = 1'b0;
        adr_src1 = 2'd0;
        adr_src2 = 2'd0;
        repeat (3) step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) read_pair("reset_sweep", 2'(i), 2'(3 - i), 3'b000, 3'b000);

        for (int i = 0; i < 4; i++) begin
            adr_dst = 2'(i);
            DATA_in = vals[i];
            write_enable = 1'b1;
            step();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 4; i++) read_pair("write_all", 2'(i), 2'(3 - i), vals[i], vals[3 - i]);

        read_pair("dual_read", 2'd3, 2'd3, 3'b001, 3'b001);

        write_enable = 1'b0;
        DATA_in = 3'b110;
        adr_dst = 2'd2;
        step();
        read_pair("write_disabled", 2'd2, 2'd0, 3'b111, 3'b101);

        adr_src1 = 2'd1;
        adr_dst = 2'd1;
        DATA_in = 3'b100;
        write_enable = 1'b1;
        push(3'b010);
        #1;
        check("rdw_before", DATA_out_1);
        step();
        write_enable = 1'b0;
        push(3'b100);
        check("rdw_after", DATA_out_1);

        adr_src1 = 2'd0;
        adr_dst = 2'd0;
        DATA_in = 3'b111;
        write_enable = 1'b1;
        reset = 1'b0;
        push(3'b101);
        #1;
        check("reset_no_async", DATA_out_1);
        step();
        reset = 1'b1;
        write_enable = 1'b0;
        for (int i = 0; i < 4; i++) read_pair("reset_vs_write", 2'(i), 2'(3 - i), 3'b000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
- REQ-001: Parameter W, default 3: data width of every register and data port, in bits.
- REQ-002: Parameter ADDR_W, default 2: address width; the register count is 2**ADDR_W (4 by default).
- REQ-003: clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-004: reset, input, 1: synchronous, active-low reset.
- REQ-005: DATA_in, input, W: write data.
- REQ-006: adr_dst, input, ADDR_W: write address.
- REQ-007: write_enable, input, 1: active-high write strobe.
- REQ-008: adr_src1, input, ADDR_W: read port 1 address.
- REQ-009: adr_src2, input, ADDR_W: read port 2 address.
- REQ-010: DATA_out_1, output, W: contents of register[adr_src1].
- REQ-011: DATA_out_2, output, W: contents of register[adr_src2].

Function
- REQ-012: The block SHALL hold 2**ADDR_W registers of W bits each, with no hardwired-zero entry.
- REQ-013: Write: on the rising edge of clk with reset=1 and write_enable=1, register[adr_dst] SHALL take the value of DATA_in; all other registers SHALL hold their values.
- REQ-014: With write_enable=0 and reset=1, no register SHALL change at the clock edge.
- REQ-015: Reads SHALL be combinational (zero latency): DATA_out_1 = register[adr_src1] and DATA_out_2 = register[adr_src2], updating within the same cycle whenever an address or the stored value changes.
- REQ-016: Read-during-write, same address: before the edge the output SHALL show the old value; after the edge it SHALL show the new value. There SHALL be no write-to-read bypass.
- REQ-017: Both read ports SHALL be independent; equal source addresses SHALL yield identical outputs.
- REQ-018: Writes SHALL store exactly W bits; there SHALL be no truncation, extension or arithmetic on the data.
- REQ-019: All address values 0 .. 2**ADDR_W-1 SHALL be valid; no out-of-range case exists.

Reset
- REQ-020: When reset=0 at a rising edge of clk, every register SHALL become 0. Both outputs SHALL therefore read 0 for any address after that edge.
- REQ-021: Reset SHALL take priority over a simultaneous write; the write SHALL be discarded.
- REQ-022: Reset SHALL have no asynchronous effect: between clock edges, asserting reset SHALL NOT alter the outputs.
- REQ-023: Register contents SHALL be undefined from power-up until the first reset edge.

Structure
- REQ-024: The block SHALL be one self-contained module with no shared package; W and ADDR_W are its only constants.
- REQ-025: The block SHALL have no sub-modules. Storage SHALL be a register array written in one clocked process, with two combinational read muxes.

Verification
- REQ-026: Reset: hold reset=0 for 3 edges, then set reset=1 and sweep adr_src1/adr_src2 over 0..3 -> both outputs read 3'b000 at every address.
- REQ-027: Write all entries: write 3'b101, 3'b010, 3'b111, 3'b001 to addresses 0..3, then read (src1=i, src2=3-i) -> each port returns the value written at its address.
- REQ-028: Write disabled: write_enable=0, DATA_in=3'b110, adr_dst=2 -> register 2 still reads 3'b111.
- REQ-029: Read-during-write: adr_src1=adr_dst=1, DATA_in=3'b100, write_enable=1 -> DATA_out_1 reads 3'b010 before the edge and 3'b100 after it.
- REQ-030: Reset versus write: reset=0 with write_enable=1, DATA_in=3'b111, adr_dst=0 at the same edge -> register 0 and all other registers read 3'b000.
- REQ-031: Dual read: adr_src1=adr_src2=3 -> both outputs are equal (3'b001).
